// File: rtl/triangle_scheduler.sv
// Triangle command scheduler: buffers draw commands in a small FIFO and issues
// them one at a time to draw_triangle, counting completions per frame.
module triangle_scheduler #(
   parameter int WIDTH        = 8,
   parameter int COLOUR_WIDTH = 3,
   parameter int DEPTH        = 4,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_ax,
   input  logic [WIDTH-1:0]        in_ay,
   input  logic [WIDTH-1:0]        in_bx,
   input  logic [WIDTH-1:0]        in_by,
   input  logic [WIDTH-1:0]        in_cx,
   input  logic [WIDTH-1:0]        in_cy,
   input  logic [COLOUR_WIDTH-1:0] in_colour,
   input  logic                    in_last,
   output logic [WIDTH-1:0]        ax,
   output logic [WIDTH-1:0]        ay,
   output logic [WIDTH-1:0]        bx,
   output logic [WIDTH-1:0]        by,
   output logic [WIDTH-1:0]        cx,
   output logic [WIDTH-1:0]        cy,
   output logic [COLOUR_WIDTH-1:0] colour,
   output logic                    draw_en,
   input  logic                    draw_done,
   output logic                    busy,
   output logic                    frame_done,
   output logic [CNT_WIDTH-1:0]    tri_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 6 * WIDTH + COLOUR_WIDTH + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CPLT  = 3'd3;
   localparam logic [2:0] S_FRAME = 3'd4;

   logic [EW-1:0]           mem_r [DEPTH];
   logic [AW:0]             wr_ptr_r;
   logic [AW:0]             rd_ptr_r;
   logic                    full_s;
   logic                    empty_s;
   logic                    push_s;
   logic                    pop_s;
   logic [2:0]              state_r;
   logic [2:0]              state_next_s;
   logic                    last_r;
   logic [WIDTH-1:0]        head_ax_s;
   logic [WIDTH-1:0]        head_ay_s;
   logic [WIDTH-1:0]        head_bx_s;
   logic [WIDTH-1:0]        head_by_s;
   logic [WIDTH-1:0]        head_cx_s;
   logic [WIDTH-1:0]        head_cy_s;
   logic [COLOUR_WIDTH-1:0] head_colour_s;
   logic                    head_last_s;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty_s  = (wr_ptr_r == rd_ptr_r);
   assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign in_ready = reset & ~full_s;
   assign push_s   = in_valid & in_ready;
   assign pop_s    = (state_r == S_IDLE) & ~empty_s;
   assign busy     = ~empty_s | (state_r != S_IDLE);

   assign {head_ax_s, head_ay_s, head_bx_s, head_by_s, head_cx_s, head_cy_s,
           head_colour_s, head_last_s} = mem_r[rd_ptr_r[AW-1:0]];

   // FIFO storage and pointers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {in_ax, in_ay, in_bx, in_by, in_cx, in_cy,
                                        in_colour, in_last};
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   // Next-state logic; draw_done only matters while a draw is outstanding.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (!empty_s) state_next_s = S_ISSUE;
            else          state_next_s = S_IDLE;
         end
         S_ISSUE: begin
            if (draw_done) state_next_s = S_CPLT;
            else           state_next_s = S_WAIT;
         end
         S_WAIT: begin
            if (draw_done) state_next_s = S_CPLT;
            else           state_next_s = S_WAIT;
         end
         S_CPLT: begin
            if (last_r) state_next_s = S_FRAME;
            else        state_next_s = S_IDLE;
         end
         S_FRAME: state_next_s = S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // State, registered strobes and the per-frame completion counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r    <= S_IDLE;
         draw_en    <= 1'b0;
         frame_done <= 1'b0;
         tri_count  <= '0;
      end else begin
         state_r    <= state_next_s;
         draw_en    <= (state_next_s == S_ISSUE);
         frame_done <= (state_next_s == S_FRAME);
         if (state_r == S_CPLT) begin
            tri_count <= tri_count + CNT_WIDTH'(1);
         end else if (state_r == S_FRAME) begin
            tri_count <= '0;
         end else begin
            tri_count <= tri_count;
         end
      end
   end

   // Operand registers load only on a pop, so they hold through the whole draw.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ax     <= '0;
         ay     <= '0;
         bx     <= '0;
         by     <= '0;
         cx     <= '0;
         cy     <= '0;
         colour <= '0;
         last_r <= 1'b0;
      end else if (pop_s) begin
         ax     <= head_ax_s;
         ay     <= head_ay_s;
         bx     <= head_bx_s;
         by     <= head_by_s;
         cx     <= head_cx_s;
         cy     <= head_cy_s;
         colour <= head_colour_s;
         last_r <= head_last_s;
      end
   end

endmodule

// File: tb/tb_triangle_scheduler.sv
// Directed testbench for triangle_scheduler: hand-computed expectations checked
// with immediate assertions.
module tb_triangle_scheduler;

   localparam int W  = 8;
   localparam int CW = 3;
   localparam int D  = 4;
   localparam int CN = 8;
   localparam int TW = 6 * W + CW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_ax, in_ay, in_bx, in_by, in_cx, in_cy;
   logic [CW-1:0] in_colour;
   logic          in_last;
   logic [W-1:0]  ax, ay, bx, by, cx, cy;
   logic [CW-1:0] colour;
   logic          draw_en;
   logic          draw_done = 1'b0;
   logic          busy;
   logic          frame_done;
   logic [CN-1:0] tri_count;
   logic [TW-1:0] ops;

   int            total = 0;
   int            bad = 0;
   int            en_pulses = 0;
   int            fd_pulses = 0;
   logic [CN-1:0] fd_cnt = '0;
   logic [TW-1:0] issued [$];

   triangle_scheduler #(.WIDTH(W), .COLOUR_WIDTH(CW), .DEPTH(D), .CNT_WIDTH(CN)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_ax(in_ax), .in_ay(in_ay), .in_bx(in_bx), .in_by(in_by),
      .in_cx(in_cx), .in_cy(in_cy), .in_colour(in_colour), .in_last(in_last),
      .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy), .colour(colour),
      .draw_en(draw_en), .draw_done(draw_done), .busy(busy),
      .frame_done(frame_done), .tri_count(tri_count)
   );

   always #5 clock = ~clock;

   assign ops = {ax, ay, bx, by, cx, cy, colour};

   // Log every issued triangle and every frame_done pulse.
   always @(negedge clock) begin
      if (draw_en) begin
         en_pulses++;
         issued.push_back(ops);
      end
      if (frame_done) begin
         fd_pulses++;
         fd_cnt = tri_count;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_in(input logic [TW-1:0] t, input logic l);
      {in_ax, in_ay, in_bx, in_by, in_cx, in_cy, in_colour} = t;
      in_last = l;
   endtask

   function automatic logic [TW-1:0] mk(input int i);
      logic [W-1:0] b;
      b = W'(i * 16 + 1);
      return {b, b + 8'd1, b + 8'd2, b + 8'd3, b + 8'd4, b + 8'd5, CW'(i)};
   endfunction

   task automatic wait_pulses(input int target, input string tag);
      int n;
      n = 0;
      while (en_pulses < target && n < 100) begin
         tick();
         n++;
      end
      check(tag, 64'(en_pulses >= target), 64'd1);
   endtask

   initial begin
      int            n;
      int            e0;
      int            f0;
      logic          stable;
      logic [TW-1:0] t1;

      t1 = {8'd10, 8'd10, 8'd50, 8'd10, 8'd30, 8'd40, 3'd3};

      // Reset held with in_valid asserted
      set_in(mk(9), 1'b1);
      in_valid = 1'b1;
      #1 reset = 1'b0;
      repeat (3) tick();
      check("rst_draw_en", 64'(draw_en), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_tri_count", 64'(tri_count), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_ops", 64'(ops), 64'd0);
      reset = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);
      tick();
      check("rel_busy", 64'(busy), 64'd0);
      check("rel_no_issue", 64'(en_pulses), 64'd0);

      // Single non-last triangle, done 20 cycles after draw_en
      set_in(t1, 1'b0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_en_before", 64'(draw_en), 64'd0);
      check("t1_busy", 64'(busy), 64'd1);
      tick();
      check("t1_en_high", 64'(draw_en), 64'd1);
      check("t1_ops", 64'(ops), 64'(t1));
      tick();
      check("t1_en_one_cycle", 64'(draw_en), 64'd0);
      stable = 1'b1;
      repeat (18) begin
         tick();
         if (ops !== t1 || draw_en !== 1'b0) stable = 1'b0;
      end
      check("t1_ops_stable", 64'(stable), 64'd1);
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      check("t1_cnt_in_cplt", 64'(tri_count), 64'd0);
      check("t1_ops_cplt", 64'(ops), 64'(t1));
      tick();
      check("t1_cnt_after", 64'(tri_count), 64'd1);
      check("t1_no_frame", 64'(fd_pulses), 64'd0);
      check("t1_idle", 64'(busy), 64'd0);

      // Short reset so the frame starts counting from zero
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("rst2_cnt", 64'(tri_count), 64'd0);

      // Three-triangle frame, last tag on the third
      e0 = en_pulses;
      f0 = fd_pulses;
      for (int k = 0; k < 3; k++) begin
         set_in(mk(k + 1), (k == 2));
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_pulses(e0 + k + 1, "frame_issue");
         repeat (3) tick();
         draw_done = 1'b1;
         tick();
         draw_done = 1'b0;
      end
      check("frame_not_yet", 64'(frame_done), 64'd0);
      tick();
      check("frame_pulse", 64'(frame_done), 64'd1);
      check("frame_total", 64'(tri_count), 64'd3);
      tick();
      check("frame_pulse_end", 64'(frame_done), 64'd0);
      check("frame_cnt_clear", 64'(tri_count), 64'd0);
      check("frame_once", 64'(fd_pulses - f0), 64'd1);
      check("frame_pulses", 64'(en_pulses - e0), 64'd3);
      for (int k = 0; k < 3; k++) begin
         check("frame_order", 64'(issued[e0 + k]), 64'(mk(k + 1)));
      end

      // Backpressure: draw_done withheld, six triangles offered
      e0 = en_pulses;
      f0 = fd_pulses;
      for (int i = 0; i < 5; i++) begin
         set_in(mk(10 + i), 1'b0);
         in_valid = 1'b1;
         check("bp_ready", 64'(in_ready), 64'd1);
         tick();
      end
      set_in(mk(15), 1'b0);
      check("bp_full", 64'(in_ready), 64'd0);
      repeat (3) tick();
      check("bp_held_off", 64'(in_ready), 64'd0);
      check("bp_one_issued", 64'(en_pulses - e0), 64'd1);
      draw_done = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("bp_ready_again", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      draw_done = 1'b0;
      check("bp_drained", 64'(busy), 64'd0);
      check("bp_pulses", 64'(en_pulses - e0), 64'd6);
      for (int k = 0; k < 6; k++) begin
         check("bp_order", 64'(issued[e0 + k]), 64'(mk(10 + k)));
      end
      check("bp_count", 64'(tri_count), 64'd6);
      check("bp_no_frame", 64'(fd_pulses - f0), 64'd0);

      // Spurious draw_done while idle
      e0 = en_pulses;
      draw_done = 1'b1;
      repeat (3) tick();
      draw_done = 1'b0;
      check("spur_count", 64'(tri_count), 64'd6);
      check("spur_no_issue", 64'(en_pulses - e0), 64'd0);

      // draw_done coincident with draw_en, followed by a normal triangle
      set_in(mk(20), 1'b0);
      in_valid = 1'b1;
      tick();
      set_in(mk(21), 1'b0);
      tick();
      in_valid = 1'b0;
      check("inst_en", 64'(draw_en), 64'd1);
      check("inst_ops", 64'(ops), 64'(mk(20)));
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      check("inst_en_low", 64'(draw_en), 64'd0);
      check("inst_cnt_cplt", 64'(tri_count), 64'd6);
      tick();
      check("inst_count", 64'(tri_count), 64'd7);
      tick();
      check("inst_next_en", 64'(draw_en), 64'd1);
      check("inst_next_ops", 64'(ops), 64'(mk(21)));
      tick();
      draw_done = 1'b1;
      tick();
      draw_done = 1'b0;
      tick();
      check("inst_next_count", 64'(tri_count), 64'd8);
      check("inst_idle", 64'(busy), 64'd0);

      // Reset during a draw with two triangles queued
      e0 = en_pulses;
      f0 = fd_pulses;
      set_in(mk(30), 1'b0);
      in_valid = 1'b1;
      tick();
      set_in(mk(31), 1'b0);
      tick();
      set_in(mk(32), 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      check("mid_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check("mid_en", 64'(draw_en), 64'd0);
      check("mid_flushed", 64'(busy), 64'd0);
      check("mid_cnt", 64'(tri_count), 64'd0);
      check("mid_ops", 64'(ops), 64'd0);
      tick();
      reset = 1'b1;
      draw_done = 1'b1;
      repeat (20) tick();
      draw_done = 1'b0;
      check("mid_no_reissue", 64'(en_pulses - e0), 64'd1);
      check("mid_no_frame", 64'(fd_pulses - f0), 64'd0);
      check("mid_cnt_after", 64'(tri_count), 64'd0);
      check("mid_idle_after", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
